// File: rtl/temp_display_sequencer_if.sv
// Sample handshake plus the four published display character codes of the
// temperature display sequencer; the averaging datapath/register bank side is the master.
interface temp_display_sequencer_if #(
    parameter int DATA_W = 11,
    parameter int CHAR_W = 9
);
    logic signed [DATA_W-1:0] sample;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     busy;
    logic [CHAR_W-1:0]        signo;
    logic [CHAR_W-1:0]        digito3;
    logic [CHAR_W-1:0]        digito2;
    logic [CHAR_W-1:0]        digito1;
    logic                     update_pulse;
    logic                     ovf;

    modport master (
        output sample, sample_valid,
        input  sample_ready, busy, signo, digito3, digito2, digito1, update_pulse, ovf
    );

    modport slave (
        input  sample, sample_valid,
        output sample_ready, busy, signo, digito3, digito2, digito1, update_pulse, ovf
    );
endinterface

// File: rtl/temp_display_sequencer.sv
// Converts a signed temperature average to sign/hundreds/tens/units display codes
// via bit-serial double dabble, with leading-zero blanking and atomic publish.
module temp_display_sequencer #(
    parameter int                DATA_W     = 11,
    parameter int                CHAR_W     = 9,
    parameter logic [CHAR_W-1:0] BLANK      = 9'h120,
    parameter logic [CHAR_W-1:0] MINUS      = 9'h12D,
    parameter logic [CHAR_W-1:0] DIGIT_BASE = 9'h130
) (
    input  logic                      clk,
    input  logic                      rst,
    temp_display_sequencer_if.slave   bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mag_q, mag_d;
    logic                neg_q, neg_d;
    logic [15:0]         bcd_q, bcd_d;
    logic [CHAR_W-1:0]   signo_q, signo_d;
    logic [CHAR_W-1:0]   digito3_q, digito3_d;
    logic [CHAR_W-1:0]   digito2_q, digito2_d;
    logic [CHAR_W-1:0]   digito1_q, digito1_d;
    logic                ovf_q, ovf_d;
    logic                update_q, update_d;

    logic                ready;
    logic                sat;
    logic [3:0]          pub_h, pub_t, pub_u;

    // One double-dabble step: correct every digit >= 5, then shift in the next magnitude bit.
    function automatic logic [15:0] bcd_step(input logic [15:0] b, input logic in_bit);
        logic [15:0] adj;
        adj = b;
        for (int i = 0; i < 4; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        return {adj[14:0], in_bit};
    endfunction

    function automatic logic [CHAR_W-1:0] digit_code(input logic [3:0] d);
        return DIGIT_BASE + CHAR_W'(d);
    endfunction

    assign ready = (state_q == S_IDLE) && !rst;

    always_comb begin : publish_digits
        sat   = (bcd_q[15:12] != 4'd0);
        pub_h = sat ? 4'd9 : bcd_q[11:8];
        pub_t = sat ? 4'd9 : bcd_q[7:4];
        pub_u = sat ? 4'd9 : bcd_q[3:0];
    end

    always_comb begin : next_state
        // NOTE: every target gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        signo_d   = signo_q;
        digito3_d = digito3_q;
        digito2_d = digito2_q;
        digito1_d = digito1_q;
        ovf_d     = ovf_q;
        update_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.sample_valid && ready) begin
                    neg_d   = bus.sample[DATA_W-1];
                    // Unsigned negate in DATA_W bits so the most negative code maps to its magnitude.
                    mag_d   = bus.sample[DATA_W-1] ? (~bus.sample + 1'b1) : bus.sample;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = bcd_step(bcd_q, mag_q[DATA_W-1]);
                mag_d = mag_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                signo_d   = neg_q ? MINUS : BLANK;
                digito3_d = (pub_h == 4'd0) ? BLANK : digit_code(pub_h);
                digito2_d = (pub_h == 4'd0 && pub_t == 4'd0) ? BLANK : digit_code(pub_t);
                digito1_d = digit_code(pub_u);
                ovf_d     = sat;
                update_d  = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : regs
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            signo_q   <= BLANK;
            digito3_q <= BLANK;
            digito2_q <= BLANK;
            digito1_q <= BLANK;
            ovf_q     <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            signo_q   <= signo_d;
            digito3_q <= digito3_d;
            digito2_q <= digito2_d;
            digito1_q <= digito1_d;
            ovf_q     <= ovf_d;
            update_q  <= update_d;
        end
    end

    assign bus.sample_ready = ready;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.signo        = signo_q;
    assign bus.digito3      = digito3_q;
    assign bus.digito2      = digito2_q;
    assign bus.digito1      = digito1_q;
    assign bus.update_pulse = update_q;
    assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_temp_display_sequencer.sv
// Randomized self-checking bench for temp_display_sequencer against an arithmetic
// decimal-display model (abs, divide/modulo, saturation at 999).
module tb_temp_display_sequencer;
    localparam int DATA_W = 11;
    localparam int CHAR_W = 9;
    localparam logic [35:0] ALL_BLANK = {4{9'h120}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    temp_display_sequencer_if #(.DATA_W(DATA_W), .CHAR_W(CHAR_W)) bus ();
    temp_display_sequencer #(.DATA_W(DATA_W), .CHAR_W(CHAR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     checks = 0;
    int     failures = 0;
    int     pulse_count = 0;
    bit     mon_on = 1'b0;
    logic [35:0] prev_codes = ALL_BLANK;
    longint accept_t = 0;
    longint prev_accept_t = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] codes();
        return {bus.signo, bus.digito3, bus.digito2, bus.digito1};
    endfunction

    // Decimal display reference: plain arithmetic on the integer value.
    function automatic void model(input int v, output logic [35:0] exp_codes, output logic exp_ovf);
        int m, h, t, u;
        logic [8:0] s, d3, d2, d1;
        m = (v < 0) ? -v : v;
        exp_ovf = (m > 999);
        if (exp_ovf) begin
            h = 9; t = 9; u = 9;
        end else begin
            h = m / 100; t = (m / 10) % 10; u = m % 10;
        end
        s  = (v < 0) ? 9'h12D : 9'h120;
        d3 = (h == 0) ? 9'h120 : 9'(9'h130 + h);
        d2 = (h == 0 && t == 0) ? 9'h120 : 9'(9'h130 + t);
        d1 = 9'(9'h130 + u);
        exp_codes = {s, d3, d2, d1};
    endfunction

    // Outputs may only change on the edge that raises update_pulse (or under reset).
    always @(posedge clk) begin
        #1;
        if (bus.update_pulse) pulse_count++;
        if (mon_on && !rst && !bus.update_pulse) check("hold", 64'(codes()), 64'(prev_codes));
        prev_codes = codes();
    end

    task automatic run_sample(input int v, input bit hold, input string tag);
        logic [35:0] exp_codes;
        logic        exp_ovf;
        logic [DATA_W-1:0] bits;
        int n, cyc, busy_cyc;
        @(negedge clk);
        n = 0;
        while (!bus.sample_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 64'(n < 50), 64'(1));
        bits = v[DATA_W-1:0];
        bus.sample = bits;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        prev_accept_t = accept_t;
        accept_t = $time;
        #1;
        if (!hold) bus.sample_valid = 1'b0;
        bus.sample = DATA_W'($urandom);
        cyc = 0;
        busy_cyc = 0;
        while (!bus.update_pulse && cyc < 40) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(12));
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(12));
        model(v, exp_codes, exp_ovf);
        check({tag, "_codes"}, 64'(codes()), 64'(exp_codes));
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        if (!hold) begin
            @(posedge clk);
            #1;
            check({tag, "_pulse_width"}, 64'(bus.update_pulse), 64'(0));
        end
    endtask

    initial begin
        int r, v, pulses_before;
        bus.sample = '0;
        bus.sample_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.sample_ready), 64'(0));
        check("rst_codes", 64'(codes()), 64'(ALL_BLANK));
        check("rst_pulse", 64'(bus.update_pulse), 64'(0));
        check("rst_ovf", 64'(bus.ovf), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(bus.sample_ready), 64'(1));
        mon_on = 1'b1;

        run_sample(25, 1'b0, "p25");
        run_sample(-7, 1'b0, "m7");
        run_sample(0, 1'b0, "zero");
        run_sample(1023, 1'b0, "max");
        run_sample(-1024, 1'b0, "min");
        run_sample(100, 1'b0, "p100");

        run_sample(305, 1'b1, "b305");
        run_sample(306, 1'b1, "b306");
        check("b306_spacing", 64'(accept_t - prev_accept_t), 64'(130));
        run_sample(307, 1'b1, "b307");
        check("b307_spacing", 64'(accept_t - prev_accept_t), 64'(130));
        @(negedge clk);
        bus.sample_valid = 1'b0;

        // Abort a conversion with reset partway through CONV.
        @(negedge clk);
        while (!bus.sample_ready) @(negedge clk);
        bus.sample = 11'd42;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        pulses_before = pulse_count;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready_in_rst", 64'(bus.sample_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("abort_no_pulse", 64'(pulse_count), 64'(pulses_before));
        check("abort_codes", 64'(codes()), 64'(ALL_BLANK));
        check("abort_ovf", 64'(bus.ovf), 64'(0));
        check("abort_idle", 64'({bus.busy, bus.sample_ready}), 64'(2'b01));
        run_sample(42, 1'b0, "p42");

        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 2047));
            v = (r >= 1024) ? r - 2048 : r;
            run_sample(v, i[0], "rand");
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/temp_display_sequencer.md
Name: temp_display_sequencer

Overview:
- Converts one signed binary temperature average into the four 9-bit display character codes (sign, hundreds, tens, units) consumed by the display register bank, which is indexed 5..8.
- Sits between the averaging datapath and the register bank. It sequences a bit-serial binary-to-BCD conversion (double dabble), applies leading-zero blanking, and publishes all four codes atomically with a one-cycle update strobe.
- Accepts new samples through a valid/ready handshake.

Parameters:
- DATA_W, 11, width of signed two's-complement input sample (range -1024..1023).
- CHAR_W, 9, width of each character code; bit 8 = display-data flag.
- BLANK, 9'h120, code for blank/space.
- MINUS, 9'h12D, code for '-'.
- DIGIT_BASE, 9'h130, code for '0'; digit d encodes as DIGIT_BASE + d.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- sample  input  DATA_W  signed temperature average
- sample_valid  input  1  sample is valid
- sample_ready  output  1  block can accept a sample
- busy  output  1  conversion in progress
- signo  output  CHAR_W  sign character to register bank index 5
- digito3  output  CHAR_W  hundreds character to index 6
- digito2  output  CHAR_W  tens character to index 7
- digito1  output  CHAR_W  units character to index 8
- update_pulse  output  1  one-cycle strobe when new codes are published
- ovf  output  1  last published value was saturated

Behaviour:
- Reset: rst is synchronous and active-high; the clock is clk.
- Reset values:
  - signo, digito3, digito2 and digito1 = BLANK.
  - update_pulse = 0, ovf = 0, busy = 0.
  - FSM = IDLE; BCD and shift registers cleared.
  - sample_ready = 0 while rst is high.
- FSM states:
  - IDLE: sample_ready = 1, busy = 0. On sample_valid && sample_ready, the sample is captured at edge E0. neg = sample[DATA_W-1]; mag = |sample|, computed unsigned in DATA_W bits so that -1024 gives 1024. The BCD accumulator (4 digits: thousands..units) is cleared. Next state is CONV.
  - CONV: lasts DATA_W cycles with a bit counter running 0..DATA_W-1. Each cycle, every BCD digit >= 5 gets +3, then {bcd, mag} shifts left by 1. Exit to COMMIT after the counter reaches DATA_W-1. sample_ready = 0, busy = 1.
  - COMMIT: one cycle, then IDLE. sample_ready = 0, busy = 1.
- Publish at the COMMIT edge, E0 + DATA_W + 1:
  - Saturation: if thousands != 0, the digits are forced to 9,9,9 and ovf = 1; otherwise ovf = 0.
  - signo = MINUS if neg, else BLANK.
  - digito3 = BLANK if hundreds == 0, else DIGIT_BASE + hundreds.
  - digito2 = BLANK if hundreds == 0 and tens == 0, else DIGIT_BASE + tens.
  - digito1 is always DIGIT_BASE + units; zero displays as '0'.
  - All four codes and ovf update on the same edge. update_pulse = 1 for exactly the following cycle.
- Latency: accept edge to published outputs = DATA_W + 1 edges (12 at default). The next accept is possible at edge E0 + DATA_W + 2 at the earliest.
- Outputs hold their last published values between updates; no partial update is ever visible.
- sample_valid while not ready: ignored, no queuing. The upstream source holds the sample until it is accepted.
- sample_valid held continuously: back-to-back conversions, one every DATA_W + 2 cycles.
- Reset mid-conversion: aborts the conversion, outputs return to BLANK, and no update_pulse is generated.
- Sample changes after accept: it is already captured and has no effect on the current conversion.

Test Plan:
- Reset with rst high for 3 cycles: all codes 0x120, update_pulse = 0, ovf = 0, sample_ready = 0 during reset and 1 on the first cycle after.
- sample = +25: after 12 edges signo = 0x120, digito3 = 0x120, digito2 = 0x132, digito1 = 0x135; update_pulse high for exactly 1 cycle; busy high for 12 cycles.
- sample = -7, then sample = 0:
  - -7 gives 0x12D, 0x120, 0x120, 0x137.
  - 0 gives 0x120, 0x120, 0x120, 0x130.
- sample = 1023, then sample = -1024:
  - 1023 gives 0x120, 0x139, 0x139, 0x139 with ovf = 1.
  - -1024 gives 0x12D, 0x139, 0x139, 0x139 with ovf = 1.
  - A following sample = 100 gives 0x120, 0x131, 0x130, 0x130 with ovf = 0.
- sample_valid held high with samples 305, 306 and 307 presented on each handshake:
  - Accepts occur exactly 13 cycles apart.
  - Outputs show 3,0,5, then 3,0,6, then 3,0,7, with the tens digit shown as '0' (0x130).
  - Codes never change between update_pulses.
- Accept sample = 42, assert rst at cycle 6 of CONV: no update_pulse, outputs 0x120, FSM returns to IDLE. A subsequent sample = 42 publishes 0x120, 0x120, 0x134, 0x132.
